// File: rtl/ds_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding N_REQ data-stream requesters onto
// one NAP tx stream. A one-cycle IDLE bubble precedes each packet; once
// granted, the owner keeps the output until its eop beat transfers.
module ds_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 4,
    localparam int unsigned IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_sop,
    input  logic [N_REQ-1:0]             req_eop,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    input  logic                         out_ready,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy,
    output logic [15:0]                  pkt_count,
    output logic                         err_sticky,
    input  logic                         err_clear
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            first_q, first_d;  // no beat of the current packet has transferred yet
    logic [15:0]     pkt_count_q, pkt_count_d;
    logic            err_q, err_d;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] grant_mask;
    logic             found;
    logic [IDW-1:0]   pick;
    logic             xfer;
    logic             err_set;

    // (base + off) mod N_REQ, valid for off < N_REQ
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[IDW-1:0];
    endfunction

    assign cand       = req_valid & req_sop;
    assign grant_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    // Round-robin search: first sop candidate at or after rr_ptr
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && cand[wrap_idx(rr_ptr_q, k)]) begin
                found = 1'b1;
                pick  = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    // Output mux: owner's stream passes straight through while LOCKED
    always_comb begin
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        out_addr  = '0;
        req_ready = '0;
        if (state_q == StLocked) begin
            out_valid          = req_valid[grant_q];
            out_sop            = req_sop[grant_q];
            out_eop            = req_eop[grant_q];
            out_data           = req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            out_addr           = req_addr[32'(grant_q) * ADDR_WIDTH +: ADDR_WIDTH];
            req_ready[grant_q] = out_ready;
        end
    end

    assign xfer = (state_q == StLocked) && out_valid && out_ready;

    // Next-state: grant, packet tracking, counters and protocol error flag
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        first_d     = first_q;
        pkt_count_d = pkt_count_q;
        err_set     = 1'b0;
        case (state_q)
            StIdle: begin
                // A non-owner presenting a beat without sop while idle is mid-packet garbage
                err_set = |(req_valid & ~req_sop & ~grant_mask);
                if (found) begin
                    state_d = StLocked;
                    grant_d = pick;
                    first_d = 1'b1;
                end
            end
            StLocked: begin
                if (xfer) begin
                    first_d = 1'b0;
                    if (out_sop && !first_q) err_set = 1'b1;
                    if (out_eop) begin
                        state_d  = StIdle;
                        rr_ptr_d = wrap_idx(grant_q, 1);
                        if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Set has priority over a coincident clear
        if (err_set)        err_d = 1'b1;
        else if (err_clear) err_d = 1'b0;
        else                err_d = err_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            first_q     <= 1'b0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            first_q     <= first_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q == StLocked);
    assign pkt_count  = pkt_count_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_ds_tx_arbiter.sv
// Self-checking bench for ds_tx_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// packet-level reference model.
module tb_ds_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      req_valid, req_sop, req_eop, req_ready;
    logic [N*DW-1:0]   req_data;
    logic [N*AW-1:0]   req_addr;
    logic              out_valid, out_sop, out_eop, out_ready;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_addr;
    logic [1:0]        grant_id;
    logic              busy, err_sticky, err_clear;
    logic [15:0]       pkt_count;

    ds_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_sop    (req_sop),
        .req_eop    (req_eop),
        .req_data   (req_data),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .pkt_count  (pkt_count),
        .err_sticky (err_sticky),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner = -1 when no packet is in progress
    int m_owner = -1, m_rr = 0, m_gid = 0, m_cnt = 0;
    bit m_first = 0, m_err = 0;
    int n_owner = -1, n_rr = 0, n_gid = 0, n_cnt = 0;
    bit n_first = 0, n_err = 0;
    int g, j;
    bit e_set;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_owner = -1; m_rr = 0; m_gid = 0; m_cnt = 0; m_first = 0; m_err = 0;
        end else begin
            m_owner = n_owner; m_rr = n_rr; m_gid = n_gid; m_cnt = n_cnt;
            m_first = n_first; m_err = n_err;
        end
    end

    // Compare DUT to model mid-cycle, then compute the model's next state
    always @(negedge clk) begin
        if (resetn) begin
            n_owner = m_owner; n_rr = m_rr; n_gid = m_gid; n_cnt = m_cnt; n_first = m_first;
            e_set = 0;
            chk("grant_id", grant_id, m_gid);
            chk("busy", busy, m_owner >= 0);
            chk("pkt_count", pkt_count, m_cnt);
            chk("err_sticky", err_sticky, m_err);
            if (m_owner < 0) begin
                chk("idle_out_valid", out_valid, 0);
                chk("idle_req_ready", req_ready, 0);
                for (int i = 0; i < N; i++)
                    if (req_valid[i] && !req_sop[i] && i != m_gid) e_set = 1;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (n_owner < 0 && req_valid[j] && req_sop[j]) begin
                        n_owner = j; n_gid = j; n_first = 1;
                    end
                end
            end else begin
                g = m_owner;
                chk("out_valid", out_valid, req_valid[g]);
                chk("out_sop", out_sop, req_sop[g]);
                chk("out_eop", out_eop, req_eop[g]);
                chk("out_data", out_data, req_data[g*DW +: DW]);
                chk("out_addr", out_addr, req_addr[g*AW +: AW]);
                chk("req_ready", req_ready, out_ready ? (1 << g) : 0);
                if (req_valid[g] && out_ready) begin
                    if (req_sop[g] && !m_first) e_set = 1;
                    n_first = 0;
                    if (req_eop[g]) begin
                        n_owner = -1;
                        n_rr = (g + 1) % N;
                        if (n_cnt < 65535) n_cnt++;
                    end
                end
            end
            n_err = e_set ? 1'b1 : (err_clear ? 1'b0 : m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0; req_sop = '0; req_eop = '0;
        req_data = '0; req_addr = '0; err_clear = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        out_ready = 1'b1;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic drive(input int i, input bit v, input bit s, input bit e,
                         input logic [DW-1:0] d, input logic [AW-1:0] a);
        req_valid[i] = v; req_sop[i] = s; req_eop[i] = e;
        req_data[i*DW +: DW] = d;
        req_addr[i*AW +: AW] = a;
    endtask

    int len[N];
    int beat[N];
    bit glitch[N];
    logic [N-1:0] acc;
    bit s_bit;
    int cb, cc;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        out_ready = 1'b1;

        // Single requester, 3-beat packet
        do_reset();
        drive(1, 1, 1, 0, 32'hA0, 4'h5);
        @(negedge clk);
        chk("a_bubble_valid", out_valid, 0);
        chk("a_bubble_ready", req_ready, 0);
        for (int b = 0; b < 3; b++) begin
            step();
            drive(1, 1, b == 0, b == 2, 32'hA0 + b, 4'h5);
            @(negedge clk);
            chk("a_grant", grant_id, 1);
            chk("a_valid", out_valid, 1);
            chk("a_data", out_data, 32'hA0 + b);
        end
        step();
        clr();
        @(negedge clk);
        chk("a_count", pkt_count, 1);
        chk("a_busy", busy, 0);

        // Round-robin with everyone offering single-beat packets
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1, 1, 1, 32'hB0 + i, i[AW-1:0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                chk("b_bubble", out_valid, 0);
            end else begin
                chk("b_valid", out_valid, 1);
                chk("b_grant", grant_id, (c / 2) % 4);
                chk("b_data", out_data, 32'hB0 + (c / 2) % 4);
            end
            step();
        end
        clr();

        // Backpressure on a 4-beat packet from req2
        do_reset();
        drive(2, 1, 1, 0, 32'hC0, 4'h2);
        step();
        cb = 0;
        cc = 0;
        while (cb < 4 && cc < 20) begin
            out_ready = (cc % 2 == 0);
            @(negedge clk);
            chk("c_ready", req_ready, out_ready ? 4'b0100 : 4'b0000);
            chk("c_data", out_data, 32'hC0 + cb);
            step();
            cc++;
            if (out_ready) begin
                cb++;
                drive(2, cb < 4, 0, cb == 3, 32'hC0 + cb, 4'h2);
            end
        end
        out_ready = 1'b1;
        clr();
        @(negedge clk);
        chk("c_count", pkt_count, 1);

        // Lock: req0 8-beat packet while req3 waits with sop
        do_reset();
        drive(0, 1, 1, 0, 32'hD0, 4'h0);
        drive(3, 1, 1, 1, 32'hDD3, 4'h3);
        @(negedge clk);
        chk("d_bubble", out_valid, 0);
        step();
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            chk("d_grant", grant_id, 0);
            chk("d_data", out_data, 32'hD0 + b);
            step();
            if (b < 7) drive(0, 1, 0, b == 6, 32'hD0 + b + 1, 4'h0);
            else drive(0, 0, 0, 0, 32'h0, 4'h0);
        end
        @(negedge clk);
        chk("d_bubble2", out_valid, 0);
        step();
        @(negedge clk);
        chk("d_next_grant", grant_id, 3);
        chk("d_next_data", out_data, 32'hDD3);
        step();
        clr();

        // Mid-packet sop sets the sticky error; clear pulse drops it
        do_reset();
        drive(1, 1, 1, 0, 32'hE0, 4'h1);
        step();
        @(negedge clk);
        chk("e_err_init", err_sticky, 0);
        step();
        drive(1, 1, 1, 0, 32'hE1, 4'h1);
        step();
        drive(1, 1, 0, 1, 32'hE2, 4'h1);
        @(negedge clk);
        chk("e_err_set", err_sticky, 1);
        step();
        clr();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("e_err_hold", err_sticky, 1);
            step();
        end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        @(negedge clk);
        chk("e_err_clr", err_sticky, 0);

        // Reset during beat 2 of 5; arbitration restarts from requester 0
        do_reset();
        drive(2, 1, 1, 1, 32'hF2, 4'h2);
        step();
        step();
        clr();
        drive(3, 1, 1, 0, 32'hF0, 4'h3);
        step();
        step();
        drive(3, 1, 0, 0, 32'hF1, 4'h3);
        @(negedge clk);
        chk("f_mid_valid", out_valid, 1);
        chk("f_mid_count", pkt_count, 1);
        #1 resetn = 1'b0;
        #1;
        chk("f_rst_valid", out_valid, 0);
        chk("f_rst_ready", req_ready, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_count", pkt_count, 0);
        chk("f_rst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        clr();
        step();
        resetn = 1'b1;
        drive(1, 1, 1, 1, 32'hF11, 4'h1);
        drive(3, 1, 1, 1, 32'hF33, 4'h3);
        @(negedge clk);
        chk("f_after_count", pkt_count, 0);
        step();
        @(negedge clk);
        chk("f_restart_grant", grant_id, 1);
        step();
        clr();

        // Randomized traffic, checked by the model every cycle
        do_reset();
        for (int i = 0; i < N; i++) begin
            len[i] = $urandom_range(1, 5);
            beat[i] = 0;
            glitch[i] = 0;
        end
        repeat (3000) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i] && !glitch[i])) begin
                    if (acc[i]) begin
                        beat[i]++;
                        if (beat[i] == len[i]) begin
                            beat[i] = 0;
                            len[i] = $urandom_range(1, 5);
                        end
                    end
                    glitch[i] = 0;
                    if ($urandom_range(0, 3) != 0) begin
                        s_bit = (beat[i] == 0);
                        if (beat[i] != 0 && $urandom_range(0, 63) == 0) s_bit = 1;
                        drive(i, 1, s_bit, beat[i] == len[i] - 1, $urandom,
                              AW'($urandom_range(0, 15)));
                    end else if (beat[i] == 0 && $urandom_range(0, 63) == 0) begin
                        drive(i, 1, 0, 0, $urandom, AW'($urandom_range(0, 15)));
                        glitch[i] = 1;
                    end else begin
                        drive(i, 0, 0, 0, 32'h0, 4'h0);
                    end
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 31) == 0);
        end
        clr();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ds_tx_arbiter.md
DS_TX_ARBITER -- requirements
Module: ds_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 256: data-stream beat width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: NoC destination address width.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ: per-requester beat valid.
REQ-007 SHALL have port req_sop, input, N_REQ: per-requester start-of-packet.
REQ-008 SHALL have port req_eop, input, N_REQ: per-requester end-of-packet.
REQ-009 SHALL have port req_data, input, N_REQ*DATA_WIDTH: requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port req_addr, input, N_REQ*ADDR_WIDTH: per-requester destination, sliced the same way.
REQ-011 SHALL have port req_ready, output, N_REQ: per-requester beat accept.
REQ-012 SHALL have ports out_valid, out_sop, out_eop (1 each), out_data (DATA_WIDTH) and out_addr (ADDR_WIDTH), all outputs, driving the NAP tx data stream.
REQ-013 SHALL have port out_ready, input, 1: NAP tx ready.
REQ-014 SHALL have port grant_id, output, clog2(N_REQ): index of the current owner.
REQ-015 SHALL have port busy, output, 1: high while in LOCKED.
REQ-016 SHALL have port pkt_count, output, 16: packets completed.
REQ-017 SHALL have port err_sticky, output, 1: protocol-violation flag.
REQ-018 SHALL have port err_clear, input, 1: synchronous clear of err_sticky.

Function
REQ-019 SHALL implement two states, IDLE and LOCKED.
REQ-020 In IDLE: candidates = req_valid & req_sop; if any candidate, SHALL register grant_id = first candidate at or after rr_ptr (wrapping modulo N_REQ) and go to LOCKED next cycle.
REQ-021 In IDLE: all req_ready SHALL be 0 and out_valid SHALL be 0, giving a one-cycle arbitration bubble per packet.
REQ-022 In LOCKED: out_valid/out_sop/out_eop/out_data/out_addr SHALL combinationally equal the granted requester's inputs.
REQ-023 In LOCKED: req_ready[grant_id] SHALL equal out_ready; all other req_ready bits SHALL be 0; zero added latency.
REQ-024 A beat SHALL transfer only on a cycle with out_valid & out_ready.
REQ-025 On a transfer with out_eop=1: state SHALL go to IDLE, rr_ptr = (grant_id+1) mod N_REQ, and pkt_count SHALL increment, saturating at 16'hFFFF.
REQ-026 A single-beat packet (sop=eop=1) SHALL complete in one LOCKED cycle.
REQ-027 Grant SHALL NOT change mid-packet regardless of other requesters' activity.
REQ-028 A granted requester dropping valid mid-packet SHALL leave the arbiter in LOCKED; no timeout.
REQ-029 err_sticky SHALL set on any of:
  - a transfer in LOCKED with sop=1 other than the first beat;
  - req_valid[i] without req_sop[i] for a non-granted i while in IDLE.
REQ-030 err_sticky SHALL hold until err_clear=1; if set and clear coincide, set wins.
REQ-031 Handshake: a requester SHALL hold valid/data stable until ready; the arbiter never asserts ready without a LOCKED grant.

Reset
REQ-032 On resetn=0, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, pkt_count=0, err_sticky=0, busy=0; out_valid=0 and req_ready=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from requester 0.

Verification
REQ-034 Single requester: req1 sends a 3-beat packet with out_ready=1 -> grant_id=1 after a 1-cycle bubble, 3 consecutive beats out, pkt_count=1, back in IDLE.
REQ-035 Round-robin: all 4 requesters continuously offer 1-beat packets -> grant order 0,1,2,3,0; one beat every 2 cycles.
REQ-036 Backpressure: out_ready toggles 1,0,1,0 during a 4-beat packet from req2 -> data order preserved; req_ready[2] tracks out_ready exactly; other req_ready bits stay 0.
REQ-037 Lock: req0 sends an 8-beat packet while req3 asserts sop -> no req3 beat appears until req0's eop transfers; req3 is granted next.
REQ-038 Error: a sop beat is inserted mid-packet -> err_sticky=1 and stays 1; err_clear pulse -> 0.
REQ-039 Reset mid-packet: resetn low during beat 2 of 5 -> outputs are 0 immediately; pkt_count=0 after release.
